// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter of the
// multi-cycle RV32 core.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10,
    RESP   = 2'b11
  } arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-macro signals of the memory port arbiter, grouped so
// the arbiter sees a slave view and the core/memory side a master view.
interface mem_port_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// instruction fetch and load/store; every output comes straight from a flop.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 6,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT out of range 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             last_grant, last_grant_nx;
  logic             gnt_port, gnt_port_nx;
  logic             lat_we, lat_we_nx;
  logic             grant_sel;

  logic             mem_en_q, mem_en_nx;
  logic             mem_we_q, mem_we_nx;
  logic [AW-1:0]    mem_addr_q, mem_addr_nx;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_nx;
  logic             if_ack_q, if_ack_nx;
  logic             d_ack_q, d_ack_nx;
  logic [DW-1:0]    if_rdata_q, if_rdata_nx;
  logic [DW-1:0]    d_rdata_q, d_rdata_nx;
  logic             busy_q;

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    last_grant_nx = last_grant;
    gnt_port_nx   = gnt_port;
    lat_we_nx     = lat_we;
    grant_sel     = PORT_IF;
    mem_en_nx     = 1'b0;
    mem_we_nx     = 1'b0;
    mem_addr_nx   = mem_addr_q;
    mem_wdata_nx  = mem_wdata_q;
    if_ack_nx     = 1'b0;
    d_ack_nx      = 1'b0;
    if_rdata_nx   = if_rdata_q;
    d_rdata_nx    = d_rdata_q;

    unique case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          // Only a contested grant moves the fairness pointer
          if (bus.if_req && bus.d_req) begin
            grant_sel     = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
            last_grant_nx = grant_sel;
          end else begin
            grant_sel = bus.d_req ? PORT_D : PORT_IF;
          end
          gnt_port_nx = grant_sel;
          if (grant_sel == PORT_D) begin
            lat_we_nx    = bus.d_we;
            mem_addr_nx  = bus.d_addr;
            mem_wdata_nx = bus.d_wdata;
          end else begin
            lat_we_nx   = 1'b0;
            mem_addr_nx = bus.if_addr;
          end
          mem_en_nx = 1'b1;
          mem_we_nx = lat_we_nx;
          state_nx  = ACCESS;
        end
      end
      ACCESS: begin
        cnt_nx   = CNT_LOAD;
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          if (!lat_we) begin
            if (gnt_port == PORT_D) d_rdata_nx  = bus.mem_rdata;
            else                    if_rdata_nx = bus.mem_rdata;
          end
          if (gnt_port == PORT_D) d_ack_nx  = 1'b1;
          else                    if_ack_nx = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= PORT_IF;
      gnt_port    <= PORT_IF;
      lat_we      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      last_grant  <= last_grant_nx;
      gnt_port    <= gnt_port_nx;
      lat_we      <= lat_we_nx;
      mem_en_q    <= mem_en_nx;
      mem_we_q    <= mem_we_nx;
      mem_addr_q  <= mem_addr_nx;
      mem_wdata_q <= mem_wdata_nx;
      if_ack_q    <= if_ack_nx;
      d_ack_q     <= d_ack_nx;
      if_rdata_q  <= if_rdata_nx;
      d_rdata_q   <= d_rdata_nx;
      busy_q      <= (state_nx != IDLE);
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance with MEM_LAT=1 for the
// functional and random runs, one with MEM_LAT=3 for latency timing.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(6), .DW(32)) bus_a ();
  mem_port_arbiter_if #(.AW(6), .DW(32)) bus_b ();

  mem_port_arbiter #(.AW(6), .DW(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  mem_port_arbiter #(.AW(6), .DW(32), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [64];
  logic [31:0] d_model [2];
  logic [31:0] a_if_q[$], a_d_q[$], b_if_q[$], b_d_q[$];
  int          en_a = 0;
  int          en_b = 0;

  function automatic logic [31:0] init_word(input logic [5:0] a);
    if (a == 6'h04) return 32'h00500093;
    return {16'hC0DE, 10'd0, a};
  endfunction

  // Memory macros: A has one cycle of read latency, B three
  logic [31:0] wmem_a [64];
  bit          wv_a   [64];
  logic [31:0] pipe_b [3];

  always @(posedge clk) begin
    if (bus_a.mem_en) begin
      if (bus_a.mem_we) begin
        wmem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        wv_a[bus_a.mem_addr]   <= 1'b1;
      end else begin
        bus_a.mem_rdata <= wv_a[bus_a.mem_addr] ? wmem_a[bus_a.mem_addr]
                                                : init_word(bus_a.mem_addr);
      end
    end
  end

  always @(posedge clk) begin
    if (bus_b.mem_en && !bus_b.mem_we) pipe_b[0] <= init_word(bus_b.mem_addr);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_b.mem_rdata = pipe_b[2];

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one request and push the value the port must return at its ack
  task automatic applyStimulus(input int inst, input logic port, input logic we,
                               input logic [5:0] addr, input logic [31:0] wdata);
    logic [31:0] exp;
    if (port == PORT_IF) begin
      exp = ref_mem[addr];
      if (inst == 0) begin
        bus_a.if_addr = addr; bus_a.if_req = 1'b1; a_if_q.push_back(exp);
      end else begin
        bus_b.if_addr = addr; bus_b.if_req = 1'b1; b_if_q.push_back(exp);
      end
    end else begin
      if (we) ref_mem[addr] = wdata;
      else    d_model[inst] = ref_mem[addr];
      exp = d_model[inst];
      if (inst == 0) begin
        bus_a.d_we = we; bus_a.d_addr = addr; bus_a.d_wdata = wdata;
        bus_a.d_req = 1'b1; a_d_q.push_back(exp);
      end else begin
        bus_b.d_we = we; bus_b.d_addr = addr; bus_b.d_wdata = wdata;
        bus_b.d_req = 1'b1; b_d_q.push_back(exp);
      end
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ctrl"}, {27'd0, bus_a.if_ack, bus_a.d_ack, bus_a.mem_en,
                                 bus_a.mem_we, bus_a.busy}, 32'd0);
    checkOutput({tag, "_addr"}, {26'd0, bus_a.mem_addr}, 32'd0);
    checkOutput({tag, "_wdata"}, bus_a.mem_wdata, 32'd0);
    checkOutput({tag, "_if_rdata"}, bus_a.if_rdata, 32'd0);
    checkOutput({tag, "_d_rdata"}, bus_a.d_rdata, 32'd0);
  endtask

  task automatic waitAck(output logic [1:0] acks);
    bit seen = 0;
    acks = 2'b00;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (bus_a.if_ack || bus_a.d_ack) begin
        acks = {bus_a.d_ack, bus_a.if_ack};
        seen = 1;
      end
    end
    if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard side: each ack pops one expectation and needs exactly one mem_en
  always @(negedge clk) begin
    if (!rst_n) begin
      en_a = 0;
    end else begin
      if (bus_a.mem_en) en_a++;
      if (bus_a.if_ack || bus_a.d_ack) begin
        checkOutput("a_dual_ack", {31'd0, bus_a.if_ack & bus_a.d_ack}, 32'd0);
        checkOutput("a_en_per_ack", en_a, 32'd1);
        en_a = 0;
      end
      if (bus_a.if_ack) begin
        if (a_if_q.size() == 0) checkOutput("a_if_spurious", 32'd1, 32'd0);
        else checkOutput("a_if_rdata", bus_a.if_rdata, a_if_q.pop_front());
      end
      if (bus_a.d_ack) begin
        if (a_d_q.size() == 0) checkOutput("a_d_spurious", 32'd1, 32'd0);
        else checkOutput("a_d_rdata", bus_a.d_rdata, a_d_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      en_b = 0;
    end else begin
      if (bus_b.mem_en) en_b++;
      if (bus_b.if_ack || bus_b.d_ack) begin
        checkOutput("b_en_per_ack", en_b, 32'd1);
        en_b = 0;
      end
      if (bus_b.if_ack) begin
        if (b_if_q.size() == 0) checkOutput("b_if_spurious", 32'd1, 32'd0);
        else checkOutput("b_if_rdata", bus_b.if_rdata, b_if_q.pop_front());
      end
      if (bus_b.d_ack) begin
        if (b_d_q.size() == 0) checkOutput("b_d_spurious", 32'd1, 32'd0);
        else checkOutput("b_d_rdata", bus_b.d_rdata, b_d_q.pop_front());
      end
    end
  end

  initial begin
    logic [1:0] acks;
    bit         if_p, d_p, ia, da;

    rst_n = 1'b0;
    bus_a.if_req = 0; bus_a.if_addr = '0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_addr = '0; bus_a.d_wdata = '0;
    bus_b.if_req = 0; bus_b.if_addr = '0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_addr = '0; bus_b.d_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(6'(i));
    d_model[0] = '0;
    d_model[1] = '0;

    tick(3);
    checkResetState("reset");
    rst_n = 1'b1;
    tick(1);

    // MEM_LAT=3: fetch at t acks at t+5, data raised at t+2 acks at t+11
    applyStimulus(1, PORT_IF, 1'b0, 6'h04, 32'd0);
    tick(2);
    applyStimulus(1, PORT_D, 1'b0, 6'h10, 32'd0);
    tick(2);
    checkOutput("lat3_if_ack_t4", {31'd0, bus_b.if_ack}, 32'd0);
    tick(1);
    checkOutput("lat3_if_ack_t5", {31'd0, bus_b.if_ack}, 32'd1);
    tick(1);
    bus_b.if_req = 1'b0;
    checkOutput("lat3_idle_t6", {31'd0, bus_b.busy}, 32'd0);
    tick(4);
    checkOutput("lat3_d_ack_t10", {31'd0, bus_b.d_ack}, 32'd0);
    tick(1);
    checkOutput("lat3_d_ack_t11", {31'd0, bus_b.d_ack}, 32'd1);
    tick(1);
    bus_b.d_req = 1'b0;

    // MEM_LAT=1 single fetch
    applyStimulus(0, PORT_IF, 1'b0, 6'h04, 32'd0);
    checkOutput("fetch_busy_t0", {31'd0, bus_a.busy}, 32'd0);
    tick(1);
    checkOutput("fetch_en_t1", {30'd0, bus_a.mem_en, bus_a.mem_we}, 32'd2);
    checkOutput("fetch_addr_t1", {26'd0, bus_a.mem_addr}, 32'h04);
    checkOutput("fetch_busy_t1", {31'd0, bus_a.busy}, 32'd1);
    tick(1);
    checkOutput("fetch_t2", {29'd0, bus_a.mem_en, bus_a.if_ack, bus_a.busy}, 32'd1);
    tick(1);
    checkOutput("fetch_t3", {30'd0, bus_a.if_ack, bus_a.busy}, 32'd3);
    tick(1);
    bus_a.if_req = 1'b0;
    checkOutput("fetch_t4", {30'd0, bus_a.if_ack, bus_a.busy}, 32'd0);

    // Store then load at the same address
    applyStimulus(0, PORT_D, 1'b1, 6'h10, 32'hDEADBEEF);
    tick(1);
    checkOutput("store_we_t1", {30'd0, bus_a.mem_en, bus_a.mem_we}, 32'd3);
    checkOutput("store_wdata_t1", bus_a.mem_wdata, 32'hDEADBEEF);
    checkOutput("store_addr_t1", {26'd0, bus_a.mem_addr}, 32'h10);
    tick(2);
    checkOutput("store_ack_t3", {31'd0, bus_a.d_ack}, 32'd1);
    tick(1);
    applyStimulus(0, PORT_D, 1'b0, 6'h10, 32'd0);
    tick(3);
    checkOutput("load_ack_t3", {31'd0, bus_a.d_ack}, 32'd1);
    tick(1);
    bus_a.d_req = 1'b0;

    // Contention: data first after reset, then alternation
    applyStimulus(0, PORT_D, 1'b0, 6'h11, 32'd0);
    applyStimulus(0, PORT_IF, 1'b0, 6'h08, 32'd0);
    waitAck(acks);
    checkOutput("grant0", {30'd0, acks}, 32'd2);
    tick(1);
    applyStimulus(0, PORT_D, 1'b0, 6'h12, 32'd0);
    waitAck(acks);
    checkOutput("grant1", {30'd0, acks}, 32'd1);
    tick(1);
    applyStimulus(0, PORT_IF, 1'b0, 6'h09, 32'd0);
    waitAck(acks);
    checkOutput("grant2", {30'd0, acks}, 32'd2);
    tick(1);
    bus_a.d_req = 1'b0;
    waitAck(acks);
    checkOutput("grant3", {30'd0, acks}, 32'd1);
    tick(1);
    bus_a.if_req = 1'b0;

    // Reset during WAIT aborts the access without an ack
    applyStimulus(0, PORT_D, 1'b0, 6'h11, 32'd0);
    tick(2);
    rst_n = 1'b0;
    #1;
    checkResetState("midrst");
    void'(a_d_q.pop_back());
    d_model[0] = '0;
    d_model[1] = '0;
    bus_a.d_req = 1'b0;
    tick(1);
    rst_n = 1'b1;
    applyStimulus(0, PORT_D, 1'b0, 6'h20, 32'd0);
    applyStimulus(0, PORT_IF, 1'b0, 6'h05, 32'd0);
    waitAck(acks);
    checkOutput("tie_after_reset", {30'd0, acks}, 32'd2);
    tick(1);
    bus_a.d_req = 1'b0;
    waitAck(acks);
    checkOutput("tie_second", {30'd0, acks}, 32'd1);
    tick(1);
    bus_a.if_req = 1'b0;

    // Random traffic; fetches stay in the low half, data in the high half
    if_p = 0;
    d_p  = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      ia = bus_a.if_ack;
      da = bus_a.d_ack;
      @(posedge clk);
      #1;
      if (ia) begin bus_a.if_req = 1'b0; if_p = 0; end
      if (da) begin bus_a.d_req = 1'b0; d_p = 0; end
      if (!if_p && $urandom_range(0, 3) != 0) begin
        applyStimulus(0, PORT_IF, 1'b0, 6'($urandom_range(0, 31)), 32'd0);
        if_p = 1;
      end
      if (!d_p && $urandom_range(0, 3) != 0) begin
        applyStimulus(0, PORT_D, 1'($urandom_range(0, 1)),
                      6'($urandom_range(32, 63)), $urandom);
        d_p = 1;
      end
    end
    for (int c = 0; c < 40 && (if_p || d_p); c++) begin
      @(negedge clk);
      ia = bus_a.if_ack;
      da = bus_a.d_ack;
      @(posedge clk);
      #1;
      if (ia) begin bus_a.if_req = 1'b0; if_p = 0; end
      if (da) begin bus_a.d_req = 1'b0; d_p = 0; end
    end
    tick(2);
    checkOutput("rand_drained", {31'd0, if_p | d_p}, 32'd0);
    checkOutput("a_if_q_left", a_if_q.size(), 32'd0);
    checkOutput("a_d_q_left", a_d_q.size(), 32'd0);
    checkOutput("b_q_left", b_if_q.size() + b_d_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
